// File: rtl/main_memory_responder_if.sv
// Memory-side bus between the cache controller (master) and the main-memory
// responder (slave).
//   mem_rd_req / mem_wr_req : level requests from the controller, held until mem_ready
//   mem_addr / mem_wdata    : word address and write data, sampled by the responder at accept
//   mem_rdata / mem_rvalid  : one refill beat per cycle during a read burst
//   mem_roff                : block offset of the current beat
//   mem_ready               : single-cycle pulse, write committed or last read beat
//   mem_err                 : sticky protocol error flag (zero unless checking is built in)
interface main_memory_responder_if #(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4
);
  localparam int unsigned OffW = $clog2(WORDS_PER_BLOCK);

  logic                  mem_rd_req;
  logic                  mem_wr_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  logic [OffW-1:0]       mem_roff;
  logic                  mem_ready;
  logic                  mem_err;

  modport master (
    output mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid, mem_roff, mem_ready, mem_err
  );

  modport slave (
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid, mem_roff, mem_ready, mem_err
  );
endinterface

// File: rtl/main_memory_responder.sv
// Backing main-memory model below the cache controller. Serves line refills as
// WORDS_PER_BLOCK-beat read bursts (critical word first, offset wraps inside the block)
// and single-word write-through writes, each after LATENCY wait cycles.
//
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset (aborts any operation; array keeps its contents)
//   bus  : main_memory_responder_if.slave (requests in; beats, ready pulse, error out)
//
// Optional feature: define MEM_PROTO_CHECK_EN to build the protocol checker that sets
// a sticky mem_err when the served request drops, or the address moves, before mem_ready.
// Without the macro mem_err is tied to 0.
//
// WORDS_PER_BLOCK must be a power of two >= 2; LATENCY must be >= 1.
module main_memory_responder #(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned LATENCY         = 4
) (
  input logic                    clk,
  input logic                    rst,
  main_memory_responder_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned OffW  = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CntW-1:0] LatInit  = CntW'(LATENCY - 1);
  localparam logic [OffW-1:0] LastBeat = OffW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRBurst,
    StWCommit
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [OffW-1:0]       beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  is_wr_q, is_wr_d;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [OffW-1:0]       roff;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  last_beat;
  logic                  rvalid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;

  // Beat offset wraps naturally in OffW bits; tag and index stay fixed for the burst.
  assign roff      = addr_q[OffW-1:0] + beat_q;
  assign rd_addr   = {addr_q[ADDR_WIDTH-1:OffW], roff};
  assign last_beat = (beat_q == LastBeat);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;

    unique case (state_q)
      StIdle: begin
        // A pending read stays held while a simultaneous write is served first.
        if (bus.mem_wr_req || bus.mem_rd_req) begin
          state_d = StWait;
          cnt_d   = LatInit;
          beat_d  = '0;
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          is_wr_d = bus.mem_wr_req;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = is_wr_q ? StWCommit : StRBurst;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWCommit: begin
        state_d = StIdle;
      end
      StRBurst: begin
        if (last_beat) begin
          state_d = StIdle;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + OffW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the current state so reset forces them to zero next cycle.
  always_comb begin
    rvalid = 1'b0;
    ready  = 1'b0;
    rdata  = '0;
    unique case (state_q)
      StRBurst: begin
        rvalid = 1'b1;
        rdata  = mem_q[rd_addr];
        ready  = last_beat;
      end
      StWCommit: begin
        ready = 1'b1;
      end
      default: begin
        rvalid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Array is never cleared; reset at the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StWCommit)) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign bus.mem_rdata  = rdata;
  assign bus.mem_rvalid = rvalid;
  assign bus.mem_roff   = rvalid ? roff : '0;
  assign bus.mem_ready  = ready;

`ifdef MEM_PROTO_CHECK_EN
  logic err_q, err_d;
  logic op_req;

  // Checked in every busy cycle except the ready cycle itself.
  always_comb begin
    op_req = is_wr_q ? bus.mem_wr_req : bus.mem_rd_req;
    err_d  = err_q;
    if ((state_q != StIdle) && !ready && (!op_req || (bus.mem_addr != addr_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.mem_err = err_q;
`else
  assign bus.mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
`timescale 1ns/1ps
module tb_main_memory_responder;
  localparam int Lat = 4;
  localparam int Wpb = 4;
  localparam int Aw  = 10;
  localparam int Dw  = 32;
`ifdef MEM_PROTO_CHECK_EN
  localparam logic ExpErr = 1'b1;
`else
  localparam logic ExpErr = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  main_memory_responder_if #(.ADDR_WIDTH(Aw), .DATA_WIDTH(Dw), .WORDS_PER_BLOCK(Wpb)) bus ();

  main_memory_responder #(
    .ADDR_WIDTH     (Aw),
    .DATA_WIDTH     (Dw),
    .WORDS_PER_BLOCK(Wpb),
    .LATENCY        (Lat)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a timeline of expected outputs per cycle slot (slot s lies between
  // clock edge s and edge s+1), filled in when the model decides an operation is accepted.
  int          edge_cnt = 0;
  bit          exp_valid [2048];
  logic [31:0] exp_rdata [2048];
  bit   [1:0]  exp_roff  [2048];
  bit          exp_ready [2048];
  logic [31:0] ref_mem   [1024];
  int          free_at = 0;
  bit          pend_wr = 1'b0;
  int          pend_edge;
  logic [9:0]  pend_addr;
  logic [31:0] pend_data;
  bit          act = 1'b0;
  bit          act_wr;
  logic [9:0]  act_addr;
  int          act_start, act_ready;
  logic        model_err = 1'b0;

  always @(posedge clk) begin
    int e;
    int off;
    int base;
    edge_cnt++;
    e = edge_cnt;
    if (rst) begin
      for (int s = e; s < e + 16; s++) begin
        exp_valid[s] = 1'b0;
        exp_roff[s]  = 2'd0;
        exp_ready[s] = 1'b0;
      end
      pend_wr   = 1'b0;
      act       = 1'b0;
      model_err = 1'b0;
      free_at   = e + 1;
    end else begin
      if (act && (e - 1 >= act_start) && (e - 1 < act_ready)) begin
        if ((act_wr ? !bus.mem_wr_req : !bus.mem_rd_req) || (bus.mem_addr !== act_addr))
          model_err = ExpErr;
      end
      if (pend_wr && pend_edge == e) begin
        ref_mem[pend_addr] = pend_data;
        pend_wr = 1'b0;
      end
      if (e >= free_at && (bus.mem_wr_req || bus.mem_rd_req)) begin
        act       = 1'b1;
        act_start = e;
        act_addr  = bus.mem_addr;
        if (bus.mem_wr_req) begin
          act_wr         = 1'b1;
          act_ready      = e + Lat;
          exp_ready[e + Lat] = 1'b1;
          pend_wr        = 1'b1;
          pend_edge      = e + Lat + 1;
          pend_addr      = bus.mem_addr;
          pend_data      = bus.mem_wdata;
          free_at        = e + Lat + 2;
        end else begin
          act_wr = 1'b0;
          base   = (int'(bus.mem_addr) / Wpb) * Wpb;
          for (int k = 0; k < Wpb; k++) begin
            off = (int'(bus.mem_addr) % Wpb + k) % Wpb;
            exp_valid[e + Lat + k] = 1'b1;
            exp_roff[e + Lat + k]  = 2'(off);
            exp_rdata[e + Lat + k] = ref_mem[base + off];
            exp_ready[e + Lat + k] = (k == Wpb - 1);
          end
          act_ready = e + Lat + Wpb - 1;
          free_at   = act_ready + 2;
        end
      end
    end
  end

  // Per-cycle comparison against the model timeline
  always @(negedge clk) begin
    int s;
    if (chk_en) begin
      s = edge_cnt;
      check("rvalid", 32'(bus.mem_rvalid), 32'(exp_valid[s]));
      check("ready", 32'(bus.mem_ready), 32'(exp_ready[s]));
      check("roff", 32'(bus.mem_roff), 32'(exp_roff[s]));
      if (!exp_valid[s]) check("rdata_idle", bus.mem_rdata, 32'h0);
      else if (!$isunknown(exp_rdata[s])) check("rdata", bus.mem_rdata, exp_rdata[s]);
      check("err", 32'(bus.mem_err), 32'(model_err));
    end
  end

  int          nbeats;
  logic [31:0] beat_data [8];
  logic [1:0]  beat_roff [8];

  task automatic start_op(input bit wr, input bit rd, input logic [9:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.mem_wr_req = wr;
    bus.mem_rd_req = rd;
    bus.mem_addr   = a;
    bus.mem_wdata  = d;
  endtask

  task automatic end_op();
    @(posedge clk);
    #1;
    bus.mem_wr_req = 1'b0;
    bus.mem_rd_req = 1'b0;
  endtask

  // Collects beats until mem_ready; rdy_cyc counts cycles from the request cycle (cycle 0).
  task automatic wait_ready(input string name, output int rdy_cyc);
    nbeats  = 0;
    rdy_cyc = -1;
    for (int k = 0; k < 40 && rdy_cyc < 0; k++) begin
      @(negedge clk);
      if (bus.mem_rvalid === 1'b1 && nbeats < 8) begin
        beat_data[nbeats] = bus.mem_rdata;
        beat_roff[nbeats] = bus.mem_roff;
        nbeats++;
      end
      if (bus.mem_ready === 1'b1) rdy_cyc = k;
    end
    if (rdy_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no mem_ready expected one within 40 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy;
    logic [31:0] t3 [4];
    logic [1:0]  r3 [4];
    logic [31:0] d3 [4];
    logic [31:0] d5 [4];
    t3 = '{32'h4, 32'h5, 32'h7, 32'h6};
    r3 = '{2'd2, 2'd3, 2'd0, 2'd1};
    d3 = '{32'h7, 32'h6, 32'h4, 32'h5};
    d5 = '{32'h4, 32'h9, 32'h7, 32'h6};
    bus.mem_rd_req = 1'b0;
    bus.mem_wr_req = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset for two cycles in the middle of a read with garbage inputs
    start_op(1'b0, 1'b1, 10'h3ff, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_rd_req = 1'b0;
    bus.mem_wr_req = 1'b1;
    bus.mem_addr   = 10'h155;
    bus.mem_wdata  = 32'hdead_beef;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_wr_req = 1'b0;
    @(negedge clk);
    check("t1_rvalid", 32'(bus.mem_rvalid), 32'h0);
    check("t1_ready", 32'(bus.mem_ready), 32'h0);
    check("t1_rdata", bus.mem_rdata, 32'h0);

    // 2: write then read-back of block 0
    start_op(1'b1, 1'b0, 10'h000, 32'h30);
    wait_ready("t2_wr", rdy);
    check("t2_wr_ready_cycle", 32'(rdy), 32'd5);
    end_op();
    start_op(1'b0, 1'b1, 10'h000, 32'h0);
    wait_ready("t2_rd", rdy);
    check("t2_rd_ready_cycle", 32'(rdy), 32'd8);
    check("t2_nbeats", 32'(nbeats), 32'd4);
    for (int i = 0; i < 4; i++) check("t2_roff", 32'(beat_roff[i]), 32'(i));
    check("t2_rdata0", beat_data[0], 32'h30);
    end_op();

    // 3: fill block 0x020, critical-word-first read at 0x022
    for (int i = 0; i < 4; i++) begin
      start_op(1'b1, 1'b0, 10'(32'h20 + i), t3[i]);
      wait_ready("t3_wr", rdy);
      end_op();
    end
    start_op(1'b0, 1'b1, 10'h022, 32'h0);
    wait_ready("t3_rd", rdy);
    for (int i = 0; i < 4; i++) begin
      check("t3_roff", 32'(beat_roff[i]), 32'(r3[i]));
      check("t3_rdata", beat_data[i], d3[i]);
    end
    end_op();

    // 4: read and write together; write wins, read follows and sees the new data
    start_op(1'b1, 1'b1, 10'h021, 32'h9);
    wait_ready("t4_wr", rdy);
    check("t4_wr_ready_cycle", 32'(rdy), 32'd5);
    check("t4_wr_no_beats", 32'(nbeats), 32'd0);
    @(posedge clk);
    #1;
    bus.mem_wr_req = 1'b0;
    wait_ready("t4_rd", rdy);
    check("t4_rd_ready_cycle", 32'(rdy), 32'd8);
    check("t4_roff0", 32'(beat_roff[0]), 32'd1);
    check("t4_rdata0", beat_data[0], 32'h9);
    end_op();

    // 5: reset after two beats aborts the burst, array untouched
    start_op(1'b0, 1'b1, 10'h020, 32'h0);
    nbeats = 0;
    for (int k = 0; k < 20 && nbeats < 2; k++) begin
      @(negedge clk);
      if (bus.mem_rvalid === 1'b1) nbeats++;
    end
    check("t5_two_beats", 32'(nbeats), 32'd2);
    rst = 1'b1;
    bus.mem_rd_req = 1'b0;
    @(negedge clk);
    check("t5_rvalid_after_rst", 32'(bus.mem_rvalid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_op(1'b0, 1'b1, 10'h020, 32'h0);
    wait_ready("t5_rd", rdy);
    for (int i = 0; i < 4; i++) check("t5_rdata", beat_data[i], d5[i]);
    end_op();

    // 6: request dropped during the wait phase
    start_op(1'b0, 1'b1, 10'h040, 32'h0);
    @(posedge clk);
    #1;
    bus.mem_rd_req = 1'b0;
    wait_ready("t6_rd", rdy);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", 32'(bus.mem_err), 32'(ExpErr));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_err_cleared", 32'(bus.mem_err), 32'h0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
